// File: rtl/gon_pkg.sv
// Shared mode encodings and the per-master tag match function for the GON X-bus.
package gon_pkg;

    localparam logic [1:0] GON_MODE_UNI   = 2'd0;
    localparam logic [1:0] GON_MODE_MASK  = 2'd1;
    localparam logic [1:0] GON_MODE_BCAST = 2'd2;

    // Widest tag the match function handles; narrower IDs are zero-extended
    // by the caller, which leaves equality and masked compares unchanged.
    localparam int GON_ID_MAX = 16;

    typedef logic [GON_ID_MAX-1:0] gon_id_t;

    // Mode 3 is reserved and never matches.
    function automatic logic gon_match(input gon_id_t    id,
                                       input gon_id_t    tag,
                                       input gon_id_t    mask,
                                       input logic [1:0] mode);
        logic m;
        m = 1'b0;
        case (mode)
            GON_MODE_UNI:   m = (id == tag);
            GON_MODE_MASK:  m = (((id ^ tag) & mask) == '0);
            GON_MODE_BCAST: m = 1'b1;
            default:        m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/gon_x_mc_unit.sv
// One master slot: scan-chain ID stage, tag match, ready/select and gated values.
module gon_x_mc_unit
    import gon_pkg::*;
#(
    parameter int ID_LEN    = 5,
    parameter int VALUE_LEN = 32,
    parameter int MA_Y      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_id_i,
    input  logic [ID_LEN-1:0]    scan_in_i,
    output logic [ID_LEN-1:0]    id_o,
    input  logic                 s_ready_i,
    input  logic                 id_loaded_i,
    input  logic [ID_LEN-1:0]    s_tag_i,
    input  logic [1:0]           cfg_mode_i,
    input  logic [ID_LEN-1:0]    cfg_mask_i,
    input  logic                 enable_i,
    input  logic [VALUE_LEN-1:0] value_i,
    output logic                 ready_o,
    output logic                 sel_o,
    output logic [VALUE_LEN-1:0] or_val_o,
    output logic [VALUE_LEN-1:0] and_val_o
);

    logic [ID_LEN-1:0] id_q, id_d;
    logic              match;

    // Scan stage: take the upstream ID while shifting, otherwise hold.
    always_comb begin
        id_d = id_q;
        if (set_id_i) begin
            id_d = scan_in_i;
        end
    end

    // ID register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

    assign id_o = id_q;

    // Match, ready and select; values not selected are forced to the
    // identity of each gather (0 for OR, all-ones for AND).
    always_comb begin
        match     = gon_match(gon_id_t'(id_q), gon_id_t'(s_tag_i),
                              gon_id_t'(cfg_mask_i), cfg_mode_i);
        ready_o   = s_ready_i & id_loaded_i & ~set_id_i & match;
        sel_o     = ready_o & enable_i;
        or_val_o  = sel_o ? value_i : '0;
        and_val_o = sel_o ? value_i : '1;
    end

    // Row index is carried for trace builds; it must be a valid row.
    if (MA_Y < 0) begin : g_bad_row
        logic bad_row_unused;
        assign bad_row_unused = 1'b0;
    end

endmodule

// File: rtl/gon_x_bus_mc.sv
// Row-level GON X-bus: scan-loaded tags, selectable match, registered OR-gather,
// sticky collision flag and wrapping transfer counter.
//
// Handshake: master_ready[i] is combinational and a master transfers in any
// cycle where master_ready[i] & master_enable[i]. The gathered value is
// presented one cycle later with s_valid=1; the slave has no way to stall it
// and must take it because it already asserted s_ready in the transfer cycle.
module gon_x_bus_mc
    import gon_pkg::*;
#(
    parameter int MASTER_NUMS = 14,
    parameter int ID_LEN      = 5,
    parameter int VALUE_LEN   = 32,
    parameter int MA_Y        = 0,
    parameter int CNT_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_ready,
    input  logic [ID_LEN-1:0]                s_tag,
    output logic                             s_valid,
    output logic [VALUE_LEN-1:0]             s_value,
    output logic [MASTER_NUMS-1:0]           master_ready,
    input  logic [MASTER_NUMS-1:0]           master_enable,
    input  logic [MASTER_NUMS*VALUE_LEN-1:0] master_value,
    input  logic                             set_id,
    input  logic [ID_LEN-1:0]                id_scan_in,
    output logic [ID_LEN-1:0]                id_scan_out,
    output logic                             id_loaded,
    input  logic [1:0]                       cfg_mode,
    input  logic [ID_LEN-1:0]                cfg_mask,
    input  logic                             err_clr,
    output logic                             err_collision,
    output logic [CNT_W-1:0]                 xfer_cnt
);

    localparam int SC_W = $clog2(MASTER_NUMS + 1);
    localparam logic [SC_W-1:0] SC_FULL = SC_W'(MASTER_NUMS);

    logic [ID_LEN-1:0]    id_w     [MASTER_NUMS];
    logic [VALUE_LEN-1:0] or_w     [MASTER_NUMS];
    logic [VALUE_LEN-1:0] and_w    [MASTER_NUMS];
    logic [MASTER_NUMS-1:0] sel_w;

    logic [SC_W-1:0]      shift_cnt_q, shift_cnt_d;
    logic                 s_valid_q,   s_valid_d;
    logic [VALUE_LEN-1:0] s_value_q,   s_value_d;
    logic                 err_q,       err_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;

    logic                 xfer;
    logic                 collision;
    logic [VALUE_LEN-1:0] or_all;
    logic [VALUE_LEN-1:0] and_all;

    assign id_loaded = (shift_cnt_q == SC_FULL);

    for (genvar i = 0; i < MASTER_NUMS; i++) begin : g_unit
        logic [ID_LEN-1:0] scan_src;
        if (i == 0) begin : g_head
            assign scan_src = id_scan_in;
        end else begin : g_link
            assign scan_src = id_w[i-1];
        end

        gon_x_mc_unit #(
            .ID_LEN    (ID_LEN),
            .VALUE_LEN (VALUE_LEN),
            .MA_Y      (MA_Y)
        ) u_unit (
            .clk         (clk),
            .rst         (rst),
            .set_id_i    (set_id),
            .scan_in_i   (scan_src),
            .id_o        (id_w[i]),
            .s_ready_i   (s_ready),
            .id_loaded_i (id_loaded),
            .s_tag_i     (s_tag),
            .cfg_mode_i  (cfg_mode),
            .cfg_mask_i  (cfg_mask),
            .enable_i    (master_enable[i]),
            .value_i     (master_value[i*VALUE_LEN +: VALUE_LEN]),
            .ready_o     (master_ready[i]),
            .sel_o       (sel_w[i]),
            .or_val_o    (or_w[i]),
            .and_val_o   (and_w[i])
        );
    end

    assign id_scan_out = id_w[MASTER_NUMS-1];

    // OR and AND gathers across all masters; unselected slots are identities.
    always_comb begin
        or_all  = '0;
        and_all = '1;
        for (int i = 0; i < MASTER_NUMS; i++) begin
            or_all  = or_all  | or_w[i];
            and_all = and_all & and_w[i];
        end
        xfer      = |sel_w;
        collision = xfer && (or_all != and_all);
    end

    // Next state for capture, scan counter, sticky error and transfer count.
    always_comb begin
        shift_cnt_d = shift_cnt_q;
        if (set_id && (shift_cnt_q != SC_FULL)) begin
            shift_cnt_d = shift_cnt_q + SC_W'(1);
        end
        s_valid_d = xfer;
        s_value_d = xfer ? or_all : '0;
        err_d     = err_q;
        if (collision) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
        cnt_d = xfer ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State registers; reset drops any in-flight value and forces a rescan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_cnt_q <= '0;
            s_valid_q   <= 1'b0;
            s_value_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            shift_cnt_q <= shift_cnt_d;
            s_valid_q   <= s_valid_d;
            s_value_q   <= s_value_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign s_valid       = s_valid_q;
    assign s_value       = s_value_q;
    assign err_collision = err_q;
    assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_gon_x_bus_mc.sv
// Directed bench for gon_x_bus_mc with hand-computed expectations.
module tb_gon_x_bus_mc;

    localparam int MN = 14;
    localparam int IL = 5;
    localparam int VL = 32;
    localparam int CW = 16;

    logic                 clk;
    logic                 rst;
    logic                 s_ready;
    logic [IL-1:0]        s_tag;
    logic                 s_valid;
    logic [VL-1:0]        s_value;
    logic [MN-1:0]        master_ready;
    logic [MN-1:0]        master_enable;
    logic [MN*VL-1:0]     master_value;
    logic                 set_id;
    logic [IL-1:0]        id_scan_in;
    logic [IL-1:0]        id_scan_out;
    logic                 id_loaded;
    logic [1:0]           cfg_mode;
    logic [IL-1:0]        cfg_mask;
    logic                 err_clr;
    logic                 err_collision;
    logic [CW-1:0]        xfer_cnt;

    int total = 0;
    int bad   = 0;

    gon_x_bus_mc #(
        .MASTER_NUMS (MN),
        .ID_LEN      (IL),
        .VALUE_LEN   (VL),
        .MA_Y        (0),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_ready       (s_ready),
        .s_tag         (s_tag),
        .s_valid       (s_valid),
        .s_value       (s_value),
        .master_ready  (master_ready),
        .master_enable (master_enable),
        .master_value  (master_value),
        .set_id        (set_id),
        .id_scan_in    (id_scan_in),
        .id_scan_out   (id_scan_out),
        .id_loaded     (id_loaded),
        .cfg_mode      (cfg_mode),
        .cfg_mask      (cfg_mask),
        .err_clr       (err_clr),
        .err_collision (err_collision),
        .xfer_cnt      (xfer_cnt)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle 1 unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_val(input int idx, input logic [VL-1:0] v);
        master_value[idx*VL +: VL] = v;
    endtask

    task automatic scan_all();
        for (int k = 0; k < MN; k++) begin
            set_id     = 1'b1;
            id_scan_in = IL'(k);
            tick();
            if (k == MN - 2) chk("loaded_after_13", 64'(id_loaded), 64'd0);
        end
        set_id = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        s_ready       = 1'b0;
        s_tag         = '0;
        master_enable = '0;
        master_value  = '0;
        set_id        = 1'b0;
        id_scan_in    = '0;
        cfg_mode      = 2'd0;
        cfg_mask      = '0;
        err_clr       = 1'b0;

        // Reset state
        #12;
        chk("rst_s_valid",   64'(s_valid),       64'd0);
        chk("rst_s_value",   64'(s_value),       64'd0);
        chk("rst_id_loaded", 64'(id_loaded),     64'd0);
        chk("rst_err",       64'(err_collision), 64'd0);
        chk("rst_cnt",       64'(xfer_cnt),      64'd0);
        chk("rst_scan_out",  64'(id_scan_out),   64'd0);
        rst = 1'b1;
        tick();

        // 1. Scan 0..13: master i ends with ID 13-i
        scan_all();
        chk("loaded_after_14", 64'(id_loaded),   64'd1);
        chk("scan_out_id13",   64'(id_scan_out), 64'd0);

        // 2. Unicast tag 5 -> master 8 only
        cfg_mode = 2'd0;
        s_tag    = 5'd5;
        s_ready  = 1'b1;
        set_val(8, 32'hDEADBEEF);
        master_enable = 14'h0100;
        #1;
        chk("uni_ready", 64'(master_ready), 64'h0100);
        tick();
        chk("uni_valid", 64'(s_valid), 64'd1);
        chk("uni_value", 64'(s_value), 64'hDEADBEEF);
        chk("uni_cnt",   64'(xfer_cnt), 64'd1);
        master_enable = '0;
        tick();
        chk("idle_valid", 64'(s_valid), 64'd0);
        chk("idle_value", 64'(s_value), 64'd0);

        // 3. Masked tag 4/11110 -> IDs 4,5 (masters 9,8), equal values
        cfg_mode = 2'd1;
        cfg_mask = 5'b11110;
        s_tag    = 5'd4;
        set_val(8, 32'h0000_00F0);
        set_val(9, 32'h0000_00F0);
        master_enable = 14'h0300;
        #1;
        chk("mask_ready", 64'(master_ready), 64'h0300);
        tick();
        chk("mask_value", 64'(s_value), 64'hF0);
        chk("mask_err",   64'(err_collision), 64'd0);
        chk("mask_cnt",   64'(xfer_cnt), 64'd2);

        // 4. Differing values collide
        set_val(8, 32'h1);
        set_val(9, 32'h2);
        tick();
        chk("coll_value", 64'(s_value), 64'h3);
        chk("coll_err",   64'(err_collision), 64'd1);
        chk("coll_cnt",   64'(xfer_cnt), 64'd3);
        master_enable = '0;
        err_clr = 1'b1;
        tick();
        chk("clr_err",   64'(err_collision), 64'd0);
        chk("clr_valid", 64'(s_valid), 64'd0);
        chk("clr_cnt",   64'(xfer_cnt), 64'd3);
        // Collision in the same cycle as err_clr keeps the flag set
        master_enable = 14'h0300;
        tick();
        chk("clr_vs_coll_err", 64'(err_collision), 64'd1);
        chk("clr_vs_coll_cnt", 64'(xfer_cnt), 64'd4);
        master_enable = '0;
        tick();
        chk("clr2_err", 64'(err_collision), 64'd0);
        err_clr = 1'b0;
        // Mask 0 matches every master
        cfg_mask = '0;
        #1;
        chk("mask0_ready", 64'(master_ready), 64'h3FFF);

        // 5. Broadcast, equal values from masters 0 and 3
        cfg_mode = 2'd2;
        set_val(0, 32'hA5);
        set_val(3, 32'hA5);
        master_enable = 14'h0009;
        #1;
        chk("bcast_ready", 64'(master_ready), 64'h3FFF);
        tick();
        chk("bcast_value", 64'(s_value), 64'hA5);
        chk("bcast_err",   64'(err_collision), 64'd0);
        chk("bcast_cnt",   64'(xfer_cnt), 64'd5);
        // Shifting blocks all ready and capture
        set_id     = 1'b1;
        id_scan_in = 5'd31;
        #1;
        chk("shift_ready", 64'(master_ready), 64'd0);
        tick();
        chk("shift_valid",  64'(s_valid), 64'd0);
        chk("shift_cnt",    64'(xfer_cnt), 64'd5);
        chk("shift_loaded", 64'(id_loaded), 64'd1);
        chk("shift_out",    64'(id_scan_out), 64'd1);
        set_id   = 1'b0;
        cfg_mode = 2'd3;
        #1;
        chk("mode3_ready", 64'(master_ready), 64'd0);

        // 6. Asynchronous reset mid-transfer
        cfg_mode = 2'd2;
        tick();
        chk("pre_rst_valid", 64'(s_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid",  64'(s_valid), 64'd0);
        chk("arst_cnt",    64'(xfer_cnt), 64'd0);
        chk("arst_loaded", 64'(id_loaded), 64'd0);
        chk("arst_ready",  64'(master_ready), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 64'(master_ready), 64'd0);
        chk("post_rst_valid", 64'(s_valid), 64'd0);
        scan_all();
        #1;
        chk("rescan_ready", 64'(master_ready), 64'h3FFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
